// File: rtl/gcm_pkg.sv
// Shared GCM types, the GF(2^128) reduction constant, the GHASH controller states
// and the byte-mask helper used for partial blocks.
package gcm_pkg;

    localparam int GCM_BLK_W = 128;

    // Bit 0 is the leftmost bit of the block and the x^0 coefficient.
    typedef logic [0:GCM_BLK_W-1] gcm_blk_t;

    localparam gcm_blk_t GCM_R = {8'he1, 120'h0};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_MUL,
        ST_LEN_MUL,
        ST_DONE
    } gcm_state_e;

    // Keeps the first nbytes bytes of a left-aligned block.
    function automatic gcm_blk_t byte_mask(input logic [4:0] nbytes);
        gcm_blk_t m;
        m = '0;
        for (int i = 0; i < 16; i++) begin
            if (5'(i) < nbytes) m[i*8 +: 8] = 8'hff;
        end
        return m;
    endfunction

endpackage

// File: rtl/gf128_mul_iter.sv
// Iterative GF(2^128) multiplier: Horner evaluation of X over H, consuming
// MUL_BITS coefficients of X per cycle, highest degree first.
module gf128_mul_iter
    import gcm_pkg::*;
#(
    parameter int MUL_BITS = 8
) (
    input  logic     clk,
    input  logic     i_rst_n,
    input  logic     i_load,
    input  gcm_blk_t i_x,
    input  gcm_blk_t i_h,
    output gcm_blk_t o_y,
    output logic     o_done
);

    localparam int N     = GCM_BLK_W / MUL_BITS;
    localparam int CNT_W = $clog2(N + 1);

    gcm_blk_t         z_q;
    gcm_blk_t         x_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;

    function automatic gcm_blk_t mul_alpha(input gcm_blk_t v);
        return (v >> 1) ^ (v[127] ? GCM_R : '0);
    endfunction

    function automatic gcm_blk_t horner(input gcm_blk_t z, input gcm_blk_t x,
                                        input gcm_blk_t h, input logic [CNT_W-1:0] chunk);
        gcm_blk_t   acc;
        logic [6:0] idx;
        acc = z;
        for (int j = 0; j < MUL_BITS; j++) begin
            idx = 7'(127 - int'(chunk) * MUL_BITS - j);
            acc = mul_alpha(acc) ^ (x[idx] ? h : '0);
        end
        return acc;
    endfunction

    // The first chunk is folded into the load cycle so the result lands N cycles later.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            z_q    <= '0;
            x_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (i_load) begin
                z_q    <= horner('0, i_x, i_h, '0);
                x_q    <= i_x;
                cnt_q  <= CNT_W'(1);
                busy_q <= (N > 1);
                done_q <= (N == 1);
            end else if (busy_q) begin
                z_q   <= horner(z_q, x_q, i_h, cnt_q);
                cnt_q <= cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign o_y    = z_q;
    assign o_done = done_q;

endmodule

// File: rtl/gcm_ghash_stream.sv
// Streaming GHASH: absorbs AAD then ciphertext blocks, masks partial blocks and
// appends the bit-length block before presenting S = GHASH_H(A, C).
module gcm_ghash_stream
    import gcm_pkg::*;
#(
    parameter int MUL_BITS = 8,
    parameter int LEN_W    = 64
) (
    input  logic         clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [127:0] i_hash_key,
    input  logic         i_blk_valid,
    output logic         o_blk_ready,
    input  logic [127:0] i_blk_data,
    input  logic [4:0]   i_blk_bytes,
    input  logic         i_blk_is_aad,
    input  logic         i_blk_last,
    input  logic         i_finish,
    output logic [127:0] o_hash,
    output logic         o_hash_valid,
    output logic         o_busy,
    output logic         o_err
);

    gcm_state_e       state_q, state_d;
    gcm_blk_t         h_q, y_q, hash_q;
    gcm_blk_t         mul_x, mul_y, len_blk, blk_masked;
    logic [LEN_W-1:0] aad_len_q, ct_len_q, blk_bits;
    logic [4:0]       eff_bytes;
    logic             err_q, seen_ct_q, part_aad_q, part_ct_q, last_q, hash_vld_q;
    logic             mul_load, mul_done, bytes_bad, partial, xfer, drop;

    assign bytes_bad  = (i_blk_bytes == 5'd0) || (i_blk_bytes > 5'd16);
    assign eff_bytes  = bytes_bad ? 5'd16 : i_blk_bytes;
    assign partial    = (eff_bytes != 5'd16);
    assign blk_masked = i_blk_data & byte_mask(eff_bytes);
    assign blk_bits   = LEN_W'({eff_bytes, 3'b000});
    assign len_blk    = {64'(aad_len_q), 64'(ct_len_q)};
    assign xfer       = (state_q == ST_ACCEPT) && i_blk_valid;
    // AAD arriving after ciphertext is consumed but never hashed.
    assign drop       = i_blk_is_aad && seen_ct_q;

    gf128_mul_iter #(.MUL_BITS(MUL_BITS)) u_mul (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .i_load  (mul_load),
        .i_x     (mul_x),
        .i_h     (h_q),
        .o_y     (mul_y),
        .o_done  (mul_done)
    );

    always_ff @(posedge clk) begin
        if (!i_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        mul_load = 1'b0;
        mul_x    = y_q ^ blk_masked;
        unique case (state_q)
            ST_ACCEPT: begin
                if (i_blk_valid) begin
                    if (!drop) begin
                        state_d  = ST_MUL;
                        mul_load = 1'b1;
                    end else if (i_blk_last) begin
                        state_d  = ST_LEN_MUL;
                        mul_load = 1'b1;
                        mul_x    = y_q ^ len_blk;
                    end
                end else if (i_finish) begin
                    state_d  = ST_LEN_MUL;
                    mul_load = 1'b1;
                    mul_x    = y_q ^ len_blk;
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    if (last_q) begin
                        state_d  = ST_LEN_MUL;
                        mul_load = 1'b1;
                        mul_x    = mul_y ^ len_blk;
                    end else begin
                        state_d = ST_ACCEPT;
                    end
                end
            end
            ST_LEN_MUL: if (mul_done) state_d = ST_DONE;
            default: ;
        endcase
        if (i_start) begin
            state_d  = ST_ACCEPT;
            mul_load = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            h_q        <= '0;
            y_q        <= '0;
            hash_q     <= '0;
            aad_len_q  <= '0;
            ct_len_q   <= '0;
            err_q      <= 1'b0;
            seen_ct_q  <= 1'b0;
            part_aad_q <= 1'b0;
            part_ct_q  <= 1'b0;
            last_q     <= 1'b0;
            hash_vld_q <= 1'b0;
        end else if (i_start) begin
            h_q        <= i_hash_key;
            y_q        <= '0;
            hash_q     <= '0;
            aad_len_q  <= '0;
            ct_len_q   <= '0;
            err_q      <= 1'b0;
            seen_ct_q  <= 1'b0;
            part_aad_q <= 1'b0;
            part_ct_q  <= 1'b0;
            last_q     <= 1'b0;
            hash_vld_q <= 1'b0;
        end else begin
            if (xfer) begin
                if (bytes_bad || drop) err_q <= 1'b1;
                if (!drop) begin
                    last_q <= i_blk_last;
                    if (i_blk_is_aad) begin
                        if (part_aad_q) err_q <= 1'b1;
                        part_aad_q <= part_aad_q | partial;
                        aad_len_q  <= aad_len_q + blk_bits;
                    end else begin
                        if (part_ct_q) err_q <= 1'b1;
                        part_ct_q <= part_ct_q | partial;
                        seen_ct_q <= 1'b1;
                        ct_len_q  <= ct_len_q + blk_bits;
                    end
                end
            end
            if (mul_done && (state_q == ST_MUL)) y_q <= mul_y;
            if (mul_done && (state_q == ST_LEN_MUL)) begin
                y_q        <= mul_y;
                hash_q     <= mul_y;
                hash_vld_q <= 1'b1;
            end
        end
    end

    assign o_blk_ready  = (state_q == ST_ACCEPT);
    assign o_busy       = (state_q == ST_MUL) || (state_q == ST_LEN_MUL);
    assign o_hash       = hash_q;
    assign o_hash_valid = hash_vld_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_gcm_ghash_stream.sv
// Scoreboard bench for gcm_ghash_stream: known GCM vectors plus a bit-serial
// GF(2^128) reference for masked, AAD and error-path cases; three multiply widths.
`timescale 1ns/1ps
module tb_gcm_ghash_stream;
    import gcm_pkg::*;

    localparam int MB = 8;
    localparam int N0 = 128 / MB;
    localparam gcm_blk_t HK   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam gcm_blk_t C1   = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam gcm_blk_t Y1   = 128'h5e2ec746917062882c85b0685353deb7;
    localparam gcm_blk_t T1   = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;
    localparam gcm_blk_t A1   = 128'hfeedfacedeadbeeffeedfacedeadbeef;
    localparam gcm_blk_t PD   = 128'hffffffff_aaaaaaaa_aaaaaaaa_aaaaaaaa;
    localparam gcm_blk_t RPOL = {8'he1, 120'h0};

    typedef struct { gcm_blk_t h; int due; } exp_t;

    logic         clk = 1'b0, rst_n = 1'b0, rst_x_n = 1'b0, start = 1'b0;
    logic         blk_valid = 1'b0, blk_is_aad = 1'b0, blk_last = 1'b0, finish = 1'b0;
    logic [127:0] hash_key = '0, blk_data = '0;
    logic [4:0]   blk_bytes = 5'd16;
    logic [127:0] hash [3];
    logic         hash_valid [3], blk_ready [3], busy [3], err [3];
    logic         prev_v [3] = '{1'b0, 1'b0, 1'b0};
    exp_t         sbq [3][$];
    int           cyc = 0, n_checks = 0, n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gcm_ghash_stream #(.MUL_BITS(MB), .LEN_W(64)) u_dut (
        .clk(clk), .i_rst_n(rst_n), .i_start(start), .i_hash_key(hash_key),
        .i_blk_valid(blk_valid), .o_blk_ready(blk_ready[0]), .i_blk_data(blk_data),
        .i_blk_bytes(blk_bytes), .i_blk_is_aad(blk_is_aad), .i_blk_last(blk_last),
        .i_finish(finish), .o_hash(hash[0]), .o_hash_valid(hash_valid[0]),
        .o_busy(busy[0]), .o_err(err[0]));

    gcm_ghash_stream #(.MUL_BITS(1), .LEN_W(64)) u_b1 (
        .clk(clk), .i_rst_n(rst_x_n), .i_start(start), .i_hash_key(hash_key),
        .i_blk_valid(blk_valid), .o_blk_ready(blk_ready[1]), .i_blk_data(blk_data),
        .i_blk_bytes(blk_bytes), .i_blk_is_aad(blk_is_aad), .i_blk_last(blk_last),
        .i_finish(finish), .o_hash(hash[1]), .o_hash_valid(hash_valid[1]),
        .o_busy(busy[1]), .o_err(err[1]));

    gcm_ghash_stream #(.MUL_BITS(128), .LEN_W(64)) u_b128 (
        .clk(clk), .i_rst_n(rst_x_n), .i_start(start), .i_hash_key(hash_key),
        .i_blk_valid(blk_valid), .o_blk_ready(blk_ready[2]), .i_blk_data(blk_data),
        .i_blk_bytes(blk_bytes), .i_blk_is_aad(blk_is_aad), .i_blk_last(blk_last),
        .i_finish(finish), .o_hash(hash[2]), .o_hash_valid(hash_valid[2]),
        .o_busy(busy[2]), .o_err(err[2]));

    // Reference multiply: textbook bit-serial form, walking X from bit 0.
    function automatic gcm_blk_t gf_mul(input gcm_blk_t a, input gcm_blk_t b);
        gcm_blk_t z, v;
        z = '0;
        v = b;
        for (int i = 0; i < 128; i++) begin
            if (a[i]) z = z ^ v;
            v = v[127] ? ((v >> 1) ^ RPOL) : (v >> 1);
        end
        return z;
    endfunction

    function automatic gcm_blk_t bmask(input int nb);
        gcm_blk_t ones;
        ones = '1;
        return ~(ones >> (8 * nb));
    endfunction

    function automatic gcm_blk_t lenblk(input logic [63:0] a, input logic [63:0] c);
        return {a, c};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic wait_ready();
        int k;
        for (k = 0; k < 2000 && blk_ready[0] !== 1'b1; k++) @(negedge clk);
        if (k == 2000) begin
            n_checks++;
            $display("FAIL wait_ready: o_blk_ready stayed %b, expected 1", blk_ready[0]);
        end
    endtask

    task automatic wait_valid(input int idx);
        int k;
        for (k = 0; k < 2000 && hash_valid[idx] !== 1'b1; k++) @(negedge clk);
        if (k == 2000) begin
            n_checks++;
            $display("FAIL wait_valid%0d: o_hash_valid stayed %b, expected 1", idx, hash_valid[idx]);
        end
    endtask

    task automatic do_start(input gcm_blk_t key);
        start = 1'b1;
        hash_key = key;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input gcm_blk_t d, input logic [4:0] nb, input logic aad,
                        input logic last, output int t);
        blk_data = d; blk_bytes = nb; blk_is_aad = aad; blk_last = last; blk_valid = 1'b1;
        wait_ready();
        @(negedge clk);
        t = cyc;
        blk_valid = 1'b0;
    endtask

    task automatic do_finish(output int t);
        finish = 1'b1;
        @(negedge clk);
        t = cyc;
        finish = 1'b0;
    endtask

    // Monitor: every rising o_hash_valid pops one expectation (value and edge).
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (hash_valid[k] === 1'b1 && prev_v[k] !== 1'b1) begin
                if (sbq[k].size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_hash%0d: got %h at cycle %0d, expected none", k, hash[k], cyc);
                end else begin
                    e = sbq[k].pop_front();
                    chk($sformatf("hash%0d", k), hash[k], e.h);
                    chk($sformatf("latency%0d", k), 128'(cyc), 128'(e.due));
                end
            end
            prev_v[k] = hash_valid[k];
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t2, low;
        gcm_blk_t y, e;

        repeat (3) @(negedge clk);
        chk("rst_hash", hash[0], '0);
        chk("rst_valid", hash_valid[0], 0);
        chk("rst_ready", blk_ready[0], 0);
        chk("rst_busy", busy[0], 0);
        chk("rst_err", err[0], 0);
        rst_n = 1'b1;

        blk_valid = 1'b1; finish = 1'b1; blk_data = C1;
        repeat (3) @(negedge clk);
        chk("idle_ready", blk_ready[0], 0);
        chk("idle_busy", busy[0], 0);
        chk("idle_valid", hash_valid[0], 0);
        blk_valid = 1'b0; finish = 1'b0;

        // empty message
        do_start(HK);
        chk("accept_ready", blk_ready[0], 1);
        do_finish(t);
        sbq[0].push_back('{h: '0, due: t + N0});
        wait_valid(0);
        chk("done_ready", blk_ready[0], 0);

        // single ciphertext block on all three multiply widths
        rst_x_n = 1'b1;
        @(negedge clk);
        do_start(HK);
        send(C1, 5'd16, 1'b0, 1'b1, t);
        sbq[0].push_back('{h: T1, due: t + 2 * N0});
        sbq[1].push_back('{h: T1, due: t + 256});
        sbq[2].push_back('{h: T1, due: t + 2});
        chk("mul_busy", busy[0], 1);
        repeat (N0) @(negedge clk);
        chk("mid_y", u_dut.y_q, Y1);
        wait_valid(1);
        @(negedge clk);
        rst_x_n = 1'b0;

        // backpressure: valid held through MUL
        do_start(HK);
        blk_data = C1; blk_bytes = 5'd16; blk_is_aad = 1'b0; blk_last = 1'b0; blk_valid = 1'b1;
        wait_ready();
        @(negedge clk);
        low = 0;
        while (blk_ready[0] !== 1'b1 && low < 1000) begin
            low++;
            @(negedge clk);
        end
        blk_valid = 1'b0;
        chk("bp_low_cycles", 128'(low), 128'(N0));
        do_finish(t);
        sbq[0].push_back('{h: T1, due: t + N0});
        wait_valid(0);

        // partial last block
        do_start(HK);
        send(PD, 5'd4, 1'b0, 1'b1, t);
        y = gf_mul(PD & bmask(4), HK);
        e = gf_mul(y ^ lenblk(64'd0, 64'd32), HK);
        sbq[0].push_back('{h: e, due: t + 2 * N0});
        wait_valid(0);
        chk("partial_err", err[0], 0);

        // AAD after ciphertext is dropped
        do_start(HK);
        send(C1, 5'd16, 1'b0, 1'b0, t);
        chk("ord_err_before", err[0], 0);
        send(A1, 5'd16, 1'b1, 1'b1, t2);
        chk("ord_err_after", err[0], 1);
        sbq[0].push_back('{h: T1, due: t2 + N0});
        wait_valid(0);
        do_start(HK);
        chk("start_clears_err", err[0], 0);

        // AAD then ciphertext with illegal byte count 0
        send(A1, 5'd16, 1'b1, 1'b0, t);
        send(C1, 5'd0, 1'b0, 1'b1, t);
        chk("bytes0_err", err[0], 1);
        y = gf_mul(A1, HK);
        y = gf_mul(y ^ C1, HK);
        e = gf_mul(y ^ lenblk(64'd128, 64'd128), HK);
        sbq[0].push_back('{h: e, due: t + 2 * N0});
        wait_valid(0);

        // partial AAD followed by another AAD block
        do_start(HK);
        send(A1, 5'd5, 1'b1, 1'b0, t);
        chk("part_err_before", err[0], 0);
        send(C1, 5'd16, 1'b1, 1'b0, t);
        chk("part_err_after", err[0], 1);
        wait_ready();
        do_finish(t);
        y = gf_mul(A1 & bmask(5), HK);
        y = gf_mul(y ^ C1, HK);
        e = gf_mul(y ^ lenblk(64'd168, 64'd0), HK);
        sbq[0].push_back('{h: e, due: t + N0});
        wait_valid(0);

        // abort during MUL, then rerun
        do_start(HK);
        send(C1, 5'd16, 1'b0, 1'b1, t);
        do_start(HK);
        chk("abort_valid", hash_valid[0], 0);
        send(C1, 5'd16, 1'b0, 1'b1, t);
        sbq[0].push_back('{h: T1, due: t + 2 * N0});
        wait_valid(0);

        // reset in the middle of the length multiply
        do_start(HK);
        send(C1, 5'd16, 1'b0, 1'b1, t);
        repeat (N0 + 2) @(negedge clk);
        chk("lenmul_busy", busy[0], 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst2_hash", hash[0], '0);
        chk("rst2_valid", hash_valid[0], 0);
        chk("rst2_ready", blk_ready[0], 0);
        chk("rst2_busy", busy[0], 0);
        chk("rst2_err", err[0], 0);
        rst_n = 1'b1;
        repeat (3 * N0) @(negedge clk);
        chk("rst2_quiet", hash_valid[0], 0);

        for (int k = 0; k < 3; k++) chk($sformatf("sb_drained%0d", k), 128'(sbq[k].size()), '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
